debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel debouncer for mechanical switch and button inputs. Each channel has its own input synchroniser, per-channel settle counter and two-state FSM. Each channel produces a clean level plus single-cycle rise and fall pulses. It replaces the single-channel synchroniser/state/counter chain and adds glitch abort: a bounce that reverts before the settle window expires restarts the channel. It sits between the board-level inputs and the control FSMs.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser (≥2)
- DEBOUNCE_CYCLES, 500000, consecutive cycles the input must differ from the level before the level updates (≥2)
- RESET_LEVEL, 1'b0, value of every level output during and after reset

- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- sig_in  input  CHANNELS  raw asynchronous switch inputs, bit i = channel i
- level  output  CHANNELS  debounced level per channel
- rise  output  CHANNELS  one-cycle pulse when the level goes 0→1
- fall  output  CHANNELS  one-cycle pulse when the level goes 1→0
- busy  output  CHANNELS  high while the channel is in COUNT

## Operation
- Synchroniser: sig_in[i] passes through SYNC_STAGES flops. sync[i] is the last stage.
- Per-channel FSM states:
  - IDLE: counter held at 0.
  - COUNT: counter increments each cycle.
- IDLE → COUNT when sync[i] != level[i]. Counter loads 1.
- COUNT, sync[i] == level[i] (bounce reverted) → IDLE, counter cleared. No pulse, no level change.
- COUNT, sync[i] != level[i], counter == DEBOUNCE_CYCLES-1 → level[i] inverts, rise[i] or fall[i] asserts per the new value, → IDLE, counter cleared.
- COUNT, otherwise → counter increments.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps: the terminal compare always fires first.
- busy[i] = (state == COUNT).
- Channels are fully independent. Simultaneous events on any subset of channels are handled in parallel with no arbitration.
- At most one of rise[i] and fall[i] is high in any cycle. Each is high for exactly one cycle per level change.

## Timing
- Reset (reset_n low, asynchronous assert):
  - all synchroniser flops = RESET_LEVEL
  - level = {CHANNELS{RESET_LEVEL}}
  - rise = fall = busy = 0
  - FSM = IDLE, counters = 0
- Reset release is synchronous in effect. The first active edge after reset_n rises samples normally.
- Latency: let E1 be the first edge that samples a new stable sig_in value.
  - sync changes at edge E(SYNC_STAGES).
  - busy rises at edge E(SYNC_STAGES+1).
  - level and pulse update at edge E(SYNC_STAGES+DEBOUNCE_CYCLES).
- The pulse is registered and aligned with the level change. It drops on the following edge.
- Glitch abort: a reversion visible on sync before the terminal edge returns the channel to IDLE on that edge. A subsequent change restarts the count from 1.
- Reset mid-COUNT: the channel aborts immediately to reset values. No pulse is emitted.
- sig_in held at the reset level through reset: no pulse after release.

## Structure
- Shared package debounce_pkg:
  - state typedef deb_state_t {IDLE, COUNT}
  - counter-width function used by both modules
- Sub-module debounce_channel holds one synchroniser, one FSM, one counter and one pulse register. It carries the same parameters minus CHANNELS.
- debounce_multi is a generate loop of CHANNELS instances plus port slicing.

## Test plan
Run with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, CHANNELS=4, RESET_LEVEL=0.
- Reset check: drive reset_n low with sig_in=4'hF → level=0, rise=fall=busy=0. Release reset and hold sig_in=0 → no pulses for 20 cycles.
- Clean press: sig_in[0] 0→1 at E1 and held → busy[0] at E3, level[0]=1 and rise[0]=1 at E10 only, level stays 1.
- Bounce abort: sig_in[1] high 5 cycles, low 3, then high and held → no level change on the first burst, busy drops. level[1] rises 10 edges after the final rise.
- Simultaneous events: ch2 rises and ch3 (pre-set to 1) falls on the same edge → rise[2] and fall[3] pulse on the same cycle.
- Mid-count reset: sig_in[0] rises, reset_n pulsed low at count 4 → level[0]=0 and no rise. After release with the input still high, a fresh full 10-edge latency applies.
- Release: level[0]=1, sig_in[0] falls and is held → fall[0] single pulse after 10 edges, rise[0] never asserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the multi-channel debouncer
package debounce_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } deb_state_t;

   // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter can never wrap.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, settle counter, two-state FSM, edge pulses
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sig_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int             CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   deb_state_t             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      end
   end

   // Pulses default low so each one lasts exactly the cycle of the level change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= RESET_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_sync != r_level) begin
                  r_state <= COUNT;
                  r_cnt   <= CNT_W'(1);
               end
            end
            COUNT: begin
               if (w_sync == r_level) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == TERM) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_level <= w_sync;
                  r_rise  <= w_sync;
                  r_fall  <= ~w_sync;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;
   assign busy  = (r_state == COUNT);

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - CHANNELS independent debouncers with per-bit port slicing
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int   CHANNELS        = 4,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] sig_in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] busy
);

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_ch
         debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL)
         ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .sig_in (sig_in[g]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g]),
            .busy   (busy[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - randomized scoreboard bench for debounce_multi
module tb_debounce_multi;

   localparam int   CH = 4;
   localparam int   SS = 2;
   localparam int   D  = 8;
   localparam logic RL = 1'b0;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [CH-1:0] sig_in;
   logic [CH-1:0] level, rise, fall, busy;

   int n_cmp = 0;
   int n_bad = 0;

   debounce_multi #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sig_in(sig_in),
      .level(level), .rise(rise), .fall(fall), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: the FSM sees sig_in as sampled SS edges earlier; the level flips
   // once that delayed input has disagreed with it on D consecutive edges.
   logic [CH-1:0]     hist[$];
   int                run[CH];
   logic [CH-1:0]     m_level;
   logic [4*CH-1:0]   exp_q[$];

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back({CH{RL}});
      for (int i = 0; i < CH; i++) run[i] = 0;
      m_level = {CH{RL}};
   endtask

   initial model_reset();

   always @(posedge clk) begin
      logic [CH-1:0] seen, e_rise, e_fall, e_busy;
      if (!reset_n) begin
         model_reset();
         exp_q.push_back({{CH{RL}}, {CH{1'b0}}, {CH{1'b0}}, {CH{1'b0}}});
      end else begin
         seen = hist.pop_front();
         hist.push_back(sig_in);
         e_rise = '0;
         e_fall = '0;
         for (int i = 0; i < CH; i++) begin
            if (seen[i] != m_level[i]) begin
               run[i]++;
               if (run[i] == D) begin
                  m_level[i] = seen[i];
                  e_rise[i]  = seen[i];
                  e_fall[i]  = ~seen[i];
                  run[i]     = 0;
               end
            end else begin
               run[i] = 0;
            end
            e_busy[i] = (run[i] != 0);
         end
         exp_q.push_back({m_level, e_rise, e_fall, e_busy});
      end
   end

   always @(posedge clk) begin
      logic [4*CH-1:0] e;
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         if ({level, rise, fall, busy} !== e) begin
            n_bad++;
            $display("FAIL outputs t=%0t got lvl=%b r=%b f=%b b=%b want lvl=%b r=%b f=%b b=%b",
                     $time, level, rise, fall, busy,
                     e[4*CH-1:3*CH], e[3*CH-1:2*CH], e[2*CH-1:CH], e[CH-1:0]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, act, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic edge_s(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      bit seen_sim;
      reset_n = 1'b0;
      sig_in  = '1;
      cyc(3);
      chk("reset_outputs", {level, rise, fall, busy}, '0);
      sig_in  = '0;
      reset_n = 1'b1;
      cyc(20);

      // Clean press on ch0: busy at E3, level/rise at E10 only.
      sig_in[0] = 1'b1;
      edge_s(2);
      chk("press_busy_E2", busy[0], 1'b0);
      edge_s(1);
      chk("press_busy_E3", busy[0], 1'b1);
      edge_s(6);
      chk("press_level_E9", {level[0], rise[0]}, 2'b00);
      edge_s(1);
      chk("press_level_E10", {level[0], rise[0]}, 2'b11);
      edge_s(1);
      chk("press_level_E11", {level[0], rise[0], busy[0]}, 3'b100);
      cyc(4);

      // Bounce abort on ch1.
      sig_in[1] = 1'b1; cyc(5);
      sig_in[1] = 1'b0; cyc(3);
      chk("bounce_no_level", level[1], 1'b0);
      sig_in[1] = 1'b1; cyc(14);
      chk("bounce_final_level", level[1], 1'b1);

      // Simultaneous rise on ch2 and fall on ch3.
      sig_in[3] = 1'b1; cyc(14);
      sig_in[2] = 1'b1;
      sig_in[3] = 1'b0;
      seen_sim = 0;
      for (int k = 0; k < 20 && !seen_sim; k++) begin
         edge_s(1);
         if (rise[2] || fall[3]) begin
            seen_sim = 1;
            chk("simultaneous_pulses", {rise[2], fall[3]}, 2'b11);
         end
      end
      if (!seen_sim) chk("simultaneous_timeout", 32'd0, 32'd1);
      cyc(6);

      // Mid-count reset on ch0.
      sig_in[0] = 1'b0; cyc(14);
      sig_in[0] = 1'b1;
      cyc(6);
      reset_n = 1'b0;
      #1;
      chk("midreset_async", {level[0], rise[0], busy[0]}, 3'b000);
      cyc(2);
      reset_n = 1'b1;
      cyc(14);
      chk("midreset_relatch", level[0], 1'b1);

      // Release on ch0.
      sig_in[0] = 1'b0; cyc(14);
      chk("release_level", level[0], 1'b0);

      // Randomized bursts with occasional resets.
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset_n = 1'b0;
            cyc($urandom_range(1, 3));
            reset_n = 1'b1;
         end
         sig_in = CH'($urandom);
         cyc($urandom_range(1, 12));
      end
      cyc(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
